// File: rtl/async_reset_sync_filter_bank.sv
// Multi-channel level synchronizer with programmable reset value, optional
// stability filter and one-cycle rise/fall pulses on the synchronized level.
module async_reset_sync_filter_bank #(
  parameter int unsigned      WIDTH         = 4,
  parameter int unsigned      DEPTH         = 3,
  parameter int unsigned      FILTER_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_rise,
  output logic [WIDTH-1:0] io_fall,
  output logic             io_changed
);

  if (DEPTH < 2) begin : g_depth_check
    $error("async_reset_sync_filter_bank: DEPTH must be at least 2");
  end
  if (WIDTH < 1) begin : g_width_check
    $error("async_reset_sync_filter_bank: WIDTH must be at least 1");
  end

  // Plain flop chain; the attribute lets CDC/STA tools recognise the synchronizer.
  (* async_reg = "true" *) logic [WIDTH-1:0] sync_q [DEPTH];
  logic [WIDTH-1:0] synced;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) sync_q[k] <= RESET_VALUE;
    end else begin
      sync_q[0] <= io_in;
      for (int k = 1; k < DEPTH; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign synced = sync_q[DEPTH-1];

  if (FILTER_CYCLES == 0) begin : g_no_filter
    assign io_out = synced;
  end else begin : g_filter
    localparam int unsigned      CNT_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [WIDTH-1:0] filt_q;

    // A channel only follows synced after FILTER_CYCLES consecutive disagreements.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        filt_q <= RESET_VALUE;
        for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (synced[i] == filt_q[i]) begin
            cnt_q[i] <= '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            filt_q[i] <= synced[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end

    assign io_out = filt_q;
  end

  logic [WIDTH-1:0] out_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) out_q <= RESET_VALUE;
    else          out_q <= io_out;
  end

  // Both io_out and out_q sit at RESET_VALUE in reset, so no pulse on entry or release.
  assign io_rise    = io_out & ~out_q;
  assign io_fall    = ~io_out & out_q;
  assign io_changed = |(io_rise | io_fall);

endmodule

// File: tb/tb_async_reset_sync_filter_bank.sv
// Scoreboard bench: four parameter variants share one stimulus stream; expected
// observations are queued by cycle number and checked by an independent monitor.
module tb_async_reset_sync_filter_bank;

  localparam int N_DUT = 4;
  // Variants: (DEPTH,FILTER) = (3,0) rv=A, (3,4), (2,1), (5,7); latency = DEPTH+FILTER.
  localparam logic [3:0] RV  [N_DUT] = '{4'hA, 4'h0, 4'h0, 4'h0};
  localparam int         LAT [N_DUT] = '{3, 7, 3, 12};

  typedef struct {
    int         dut;
    int         cyc;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       chg;
    string      name;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] io_in = 4'h0;
  logic [3:0] out_w  [N_DUT];
  logic [3:0] rise_w [N_DUT];
  logic [3:0] fall_w [N_DUT];
  logic       chg_w  [N_DUT];

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb_q[$];
  exp_t keep_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  async_reset_sync_filter_bank #(.WIDTH(4), .DEPTH(3), .FILTER_CYCLES(0), .RESET_VALUE(4'hA)) dut0 (
    .clock(clock), .reset_n(reset_n), .io_in(io_in),
    .io_out(out_w[0]), .io_rise(rise_w[0]), .io_fall(fall_w[0]), .io_changed(chg_w[0]));
  async_reset_sync_filter_bank #(.WIDTH(4), .DEPTH(3), .FILTER_CYCLES(4), .RESET_VALUE(4'h0)) dut1 (
    .clock(clock), .reset_n(reset_n), .io_in(io_in),
    .io_out(out_w[1]), .io_rise(rise_w[1]), .io_fall(fall_w[1]), .io_changed(chg_w[1]));
  async_reset_sync_filter_bank #(.WIDTH(4), .DEPTH(2), .FILTER_CYCLES(1), .RESET_VALUE(4'h0)) dut2 (
    .clock(clock), .reset_n(reset_n), .io_in(io_in),
    .io_out(out_w[2]), .io_rise(rise_w[2]), .io_fall(fall_w[2]), .io_changed(chg_w[2]));
  async_reset_sync_filter_bank #(.WIDTH(4), .DEPTH(5), .FILTER_CYCLES(7), .RESET_VALUE(4'h0)) dut3 (
    .clock(clock), .reset_n(reset_n), .io_in(io_in),
    .io_out(out_w[3]), .io_rise(rise_w[3]), .io_fall(fall_w[3]), .io_changed(chg_w[3]));

  task automatic expect_at(input int d, input int at, input logic [3:0] o,
                           input logic [3:0] r, input logic [3:0] f, input string nm);
    exp_t e;
    e.dut  = d;
    e.cyc  = at;
    e.out  = o;
    e.rise = r;
    e.fall = f;
    e.chg  = ((r | f) != 4'h0);
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // Level change applied at cycle c: old value until c+LAT-1, pulse at c+LAT, quiet after.
  task automatic expect_step(input int d, input int c, input logic [3:0] old_v,
                             input logic [3:0] new_v, input string nm);
    int l;
    l = LAT[d];
    expect_at(d, c + l - 1, old_v, 4'h0, 4'h0, nm);
    expect_at(d, c + l, new_v, new_v & ~old_v, old_v & ~new_v, nm);
    expect_at(d, c + l + 1, new_v, 4'h0, 4'h0, nm);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic step_all(input logic [3:0] old_v, input logic [3:0] new_v, input string nm);
    int c;
    c = cyc;
    io_in = new_v;
    for (int d = 0; d < N_DUT; d++) expect_step(d, c, old_v, new_v, nm);
    tick(16);
  endtask

  task automatic compare(input exp_t e);
    n_total++;
    if (out_w[e.dut] === e.out && rise_w[e.dut] === e.rise &&
        fall_w[e.dut] === e.fall && chg_w[e.dut] === e.chg) begin
      n_pass++;
    end else begin
      $display("FAIL %s dut%0d cyc%0d: got out=%h rise=%h fall=%h chg=%b, expected out=%h rise=%h fall=%h chg=%b",
               e.name, e.dut, e.cyc, out_w[e.dut], rise_w[e.dut], fall_w[e.dut], chg_w[e.dut],
               e.out, e.rise, e.fall, e.chg);
    end
  endtask

  // Monitor: consumes every queued expectation that falls due on this cycle.
  initial begin
    forever begin
      @(negedge clock);
      keep_q = {};
      foreach (sb_q[i]) begin
        if (sb_q[i].cyc == cyc) begin
          compare(sb_q[i]);
        end else if (sb_q[i].cyc < cyc) begin
          n_total++;
          $display("FAIL %s dut%0d: expectation for cyc%0d never sampled (now cyc%0d)",
                   sb_q[i].name, sb_q[i].dut, sb_q[i].cyc, cyc);
        end else begin
          keep_q.push_back(sb_q[i]);
        end
      end
      sb_q = keep_q;
    end
  end

  initial begin
    int c;
    int r;

    // Reset with inputs differing from the reset value, then release on matching inputs.
    reset_n = 1'b0;
    io_in   = 4'hF;
    tick(1);
    for (int d = 0; d < N_DUT; d++) expect_at(d, 2, RV[d], 4'h0, 4'h0, "reset_hold");
    tick(2);
    io_in = 4'hA;
    tick(1);
    reset_n = 1'b1;
    c = cyc;
    for (int d = 0; d < N_DUT; d++) expect_step(d, c, RV[d], 4'hA, "release");
    tick(16);

    step_all(4'hA, 4'hB, "rise_bit0");
    step_all(4'hB, 4'h5, "to_0101");
    step_all(4'h5, 4'hA, "swap_0101_1010");
    step_all(4'hA, 4'h0, "clear");

    // 3-cycle glitch on bit 1: passes the unfiltered/N=1 variants, dropped by N=4 and N=7.
    c = cyc;
    io_in = 4'h2;
    for (int k = 1; k <= 16; k++) begin
      expect_at(1, c + k, 4'h0, 4'h0, 4'h0, "glitch3_f4");
      expect_at(3, c + k, 4'h0, 4'h0, 4'h0, "glitch3_f7");
    end
    for (int d = 0; d <= 2; d += 2) begin
      expect_at(d, c + 2, 4'h0, 4'h0, 4'h0, "glitch3_pass");
      expect_at(d, c + 3, 4'h2, 4'h2, 4'h0, "glitch3_pass");
      expect_at(d, c + 5, 4'h2, 4'h0, 4'h0, "glitch3_pass");
      expect_at(d, c + 6, 4'h0, 4'h0, 4'h2, "glitch3_pass");
      expect_at(d, c + 7, 4'h0, 4'h0, 4'h0, "glitch3_pass");
    end
    tick(3);
    io_in = 4'h0;
    tick(17);

    // 6-cycle pulse: accepted by N=4 after 7 edges, still dropped by N=7.
    c = cyc;
    io_in = 4'h2;
    expect_at(1, c + 6,  4'h0, 4'h0, 4'h0, "pulse6_f4");
    expect_at(1, c + 7,  4'h2, 4'h2, 4'h0, "pulse6_f4");
    expect_at(1, c + 8,  4'h2, 4'h0, 4'h0, "pulse6_f4");
    expect_at(1, c + 12, 4'h2, 4'h0, 4'h0, "pulse6_f4");
    expect_at(1, c + 13, 4'h0, 4'h0, 4'h2, "pulse6_f4");
    expect_at(1, c + 14, 4'h0, 4'h0, 4'h0, "pulse6_f4");
    for (int d = 0; d <= 2; d += 2) begin
      expect_at(d, c + 3,  4'h2, 4'h2, 4'h0, "pulse6_pass");
      expect_at(d, c + 9,  4'h0, 4'h0, 4'h2, "pulse6_pass");
      expect_at(d, c + 10, 4'h0, 4'h0, 4'h0, "pulse6_pass");
    end
    for (int k = 1; k <= 24; k++) expect_at(3, c + k, 4'h0, 4'h0, 4'h0, "pulse6_f7");
    tick(6);
    io_in = 4'h0;
    tick(22);

    // Reset while dut1 holds a partial count of 2, then release with the input held.
    c = cyc;
    io_in = 4'hF;
    expect_at(0, c + 3, 4'hF, 4'hF, 4'h0, "pre_reset");
    expect_at(0, c + 4, 4'hF, 4'h0, 4'h0, "pre_reset");
    expect_at(1, c + 4, 4'h0, 4'h0, 4'h0, "pre_reset");
    for (int d = 0; d < N_DUT; d++) begin
      expect_at(d, c + 5, RV[d], 4'h0, 4'h0, "async_reset");
      expect_at(d, c + 7, RV[d], 4'h0, 4'h0, "async_reset");
    end
    tick(5);
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    r = cyc;
    for (int d = 0; d < N_DUT; d++) expect_step(d, r, RV[d], 4'hF, "post_reset");
    tick(16);

    for (int k = 0; k < 50 && sb_q.size() > 0; k++) tick(1);
    if (sb_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
